// File: rtl/shift_seq_pkg.sv
// Shared types and helpers for the shift_seq_arbiter block.
//   state_e   : controller state encoding (idle, shifting data, flushing chain)
//   own_width : index width for n items, never less than one bit
package shift_seq_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StFlush = 2'd2
  } state_e;

  function automatic int unsigned own_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/shift_seq_arbiter_if.sv
// Requester / serial-chain bundle for shift_seq_arbiter.
//   master : requester side drives req_valid/req_data; observes everything else
//   slave  : the arbiter; returns req_ready and the serial/status outputs
interface shift_seq_arbiter_if
  import shift_seq_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned WIDTH   = 8
);
  localparam int unsigned OWN_W = own_width(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     ser_out;
  logic                     ser_en;
  logic [OWN_W-1:0]         owner;
  logic                     busy;
  logic                     done_pulse;
  logic [OWN_W-1:0]         done_owner;

  modport master (
    output req_valid, req_data,
    input  req_ready, ser_out, ser_en, owner, busy, done_pulse, done_owner
  );

  modport slave (
    input  req_valid, req_data,
    output req_ready, ser_out, ser_en, owner, busy, done_pulse, done_owner
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker.
//   req_i     : request vector
//   ptr_i     : index with highest priority this cycle
//   en_i      : grant allowed
//   gnt_o     : one-hot grant (all zero when disabled or no request)
//   gnt_idx_o : index of the granted requester
module rr_arbiter
  import shift_seq_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  localparam int unsigned OWN_W  = own_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [OWN_W-1:0]   ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [OWN_W-1:0]   gnt_idx_o
);

  logic [OWN_W-1:0] idx;
  logic             found;

  // Scan upward from the pointer with wrap-around; first hit wins.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = OWN_W'((32'(ptr_i) + off) % NUM_REQ);
      if (en_i && !found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        gnt_idx_o  = idx;
      end
    end
  end

endmodule

// File: rtl/shift_seq_arbiter.sv
// Round-robin arbiter that serializes one granted parallel word MSB-first onto a
// shared DEPTH-stage shift chain, then clocks DEPTH zeros so the last bit clears
// the chain, then strobes completion.
//   clk, resetn : clock, synchronous active-low reset
//   bus_io      : slave side of shift_seq_arbiter_if (requests in, serial/status out)
// Optional: define SHIFT_PARITY_EN to append an even-parity bit after the word.
module shift_seq_arbiter
  import shift_seq_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned DEPTH   = 4
) (
  input logic               clk,
  input logic               resetn,
  shift_seq_arbiter_if.slave bus_io
);

  localparam int unsigned OWN_W = own_width(NUM_REQ);
`ifdef SHIFT_PARITY_EN
  localparam int unsigned FRAME_W = WIDTH + 1;
`else
  localparam int unsigned FRAME_W = WIDTH;
`endif
  localparam int unsigned CNT_MAX = (FRAME_W > DEPTH) ? FRAME_W : DEPTH;
  localparam int unsigned CNT_W   = own_width(CNT_MAX);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-1:0] sreg_q, sreg_d;
  logic [OWN_W-1:0]   owner_q, owner_d;
  logic [OWN_W-1:0]   ptr_q, ptr_d;
  logic [OWN_W-1:0]   done_owner_q, done_owner_d;
  logic               ser_out_q, ser_out_d;
  logic               ser_en_q, ser_en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [NUM_REQ-1:0] gnt;
  logic [OWN_W-1:0]   gnt_idx;
  logic [WIDTH-1:0]   word;
  logic [FRAME_W-1:0] frame;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_arb (
    .req_i    (bus_io.req_valid),
    .ptr_i    (ptr_q),
    .en_i     (resetn && (state_q == StIdle)),
    .gnt_o    (gnt),
    .gnt_idx_o(gnt_idx)
  );

  assign bus_io.req_ready = gnt;

  always_comb begin
    word = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) word = word | bus_io.req_data[i*WIDTH +: WIDTH];
    end
  end

`ifdef SHIFT_PARITY_EN
  assign frame = {word, ^word};
`else
  assign frame = word;
`endif

  // Serial outputs are registered, so every branch computes the bit that will
  // be visible in the following cycle.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sreg_d       = sreg_q;
    owner_d      = owner_q;
    ptr_d        = ptr_q;
    done_owner_d = done_owner_q;
    ser_out_d    = 1'b0;
    ser_en_d     = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|gnt) begin
          state_d   = StShift;
          cnt_d     = '0;
          owner_d   = gnt_idx;
          ptr_d     = (gnt_idx == OWN_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
          ser_out_d = frame[FRAME_W-1];
          sreg_d    = frame << 1;
          ser_en_d  = 1'b1;
          busy_d    = 1'b1;
        end
      end
      StShift: begin
        ser_en_d = 1'b1;
        busy_d   = 1'b1;
        if (cnt_q == CNT_W'(FRAME_W - 1)) begin
          state_d = StFlush;
          cnt_d   = '0;
        end else begin
          cnt_d     = cnt_q + 1'b1;
          ser_out_d = sreg_q[FRAME_W-1];
          sreg_d    = sreg_q << 1;
        end
      end
      StFlush: begin
        if (cnt_q == CNT_W'(DEPTH - 1)) begin
          state_d      = StIdle;
          cnt_d        = '0;
          done_d       = 1'b1;
          done_owner_d = owner_q;
        end else begin
          cnt_d    = cnt_q + 1'b1;
          ser_en_d = 1'b1;
          busy_d   = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      sreg_q       <= '0;
      owner_q      <= '0;
      ptr_q        <= '0;
      done_owner_q <= '0;
      ser_out_q    <= 1'b0;
      ser_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sreg_q       <= sreg_d;
      owner_q      <= owner_d;
      ptr_q        <= ptr_d;
      done_owner_q <= done_owner_d;
      ser_out_q    <= ser_out_d;
      ser_en_q     <= ser_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus_io.ser_out    = ser_out_q;
  assign bus_io.ser_en     = ser_en_q;
  assign bus_io.owner      = owner_q;
  assign bus_io.busy       = busy_q;
  assign bus_io.done_pulse = done_q;
  assign bus_io.done_owner = done_owner_q;

endmodule

// File: tb/tb_shift_seq_arbiter.sv
// Self-checking bench for shift_seq_arbiter. A transfer is modelled as a queue
// of serial bits (word MSB-first, optional parity, DEPTH zeros); the chain is
// busy while the queue is non-empty and completion is flagged when it drains.
module tb_shift_seq_arbiter;
  import shift_seq_pkg::*;

  localparam int unsigned NUM_REQ = 2;
  localparam int unsigned WIDTH   = 8;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned OWN_W   = own_width(NUM_REQ);
`ifdef SHIFT_PARITY_EN
  localparam int unsigned SL = WIDTH + 1;
`else
  localparam int unsigned SL = WIDTH;
`endif
  localparam int unsigned PERIOD = SL + DEPTH + 1;
  localparam int unsigned VW     = NUM_REQ + 4 + 2 * OWN_W;

  logic clk = 1'b0;
  logic resetn = 1'b0;

  shift_seq_arbiter_if #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH)) bus ();

  shift_seq_arbiter #(
    .NUM_REQ(NUM_REQ),
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus_io(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Requester intent
  logic [NUM_REQ-1:0] rv;
  logic [WIDTH-1:0]   rd [NUM_REQ];

  // Reference model
  bit          m_stream[$];
  int unsigned m_owner = 0;
  int unsigned m_ptr = 0;
  int unsigned m_done_owner = 0;
  bit          m_done = 1'b0;

  task automatic apply();
    bus.req_valid = rv;
    for (int i = 0; i < NUM_REQ; i++) bus.req_data[i*WIDTH +: WIDTH] = rd[i];
  endtask

  function automatic int model_grant();
    if (!resetn || m_stream.size() != 0) return -1;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      int unsigned i = (m_ptr + off) % NUM_REQ;
      if (rv[i]) return int'(i);
    end
    return -1;
  endfunction

  function automatic logic [VW-1:0] model_expect();
    logic [NUM_REQ-1:0] rdy = '0;
    int g = model_grant();
    bit act = (m_stream.size() != 0);
    if (g >= 0) rdy[g] = 1'b1;
    return {rdy, act, act ? m_stream[0] : 1'b0, act, m_done,
            OWN_W'(m_owner), OWN_W'(m_done_owner)};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {bus.req_ready, bus.ser_en, bus.ser_out, bus.busy, bus.done_pulse,
            bus.owner, bus.done_owner};
  endfunction

  // Advance the model across the coming rising edge; an accepted requester
  // then lowers its valid.
  function automatic void model_advance();
    int g = model_grant();
    if (!resetn) begin
      m_stream.delete();
      m_ptr = 0; m_owner = 0; m_done = 1'b0; m_done_owner = 0;
    end else if (m_stream.size() != 0) begin
      void'(m_stream.pop_front());
      m_done = 1'b0;
      if (m_stream.size() == 0) begin
        m_done = 1'b1;
        m_done_owner = m_owner;
      end
    end else begin
      m_done = 1'b0;
      if (g >= 0) begin
        m_owner = g;
        m_ptr = (g + 1) % NUM_REQ;
        for (int b = WIDTH - 1; b >= 0; b--) m_stream.push_back(rd[g][b]);
`ifdef SHIFT_PARITY_EN
        m_stream.push_back(^rd[g]);
`endif
        repeat (DEPTH) m_stream.push_back(1'b0);
        rv[g] = 1'b0;
      end
    end
  endfunction

  task automatic do_reset();
    repeat (2) begin
      @(negedge clk);
      resetn = 1'b0;
      rv = '0;
      apply();
      model_advance();
    end
  endtask

  task automatic test_reset();
    logic [VW-1:0] got, exp;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      resetn = 1'b0;
      rv = '1;
      for (int i = 0; i < NUM_REQ; i++) rd[i] = WIDTH'($urandom);
      apply(); #1;
      got = dut_vec(); exp = model_expect(); checks++;
      if (got !== exp) begin
        errors++; $display("FAIL reset cyc%0d got %b exp %b", c, got, exp);
      end
      model_advance();
    end
    rv = '0;
  endtask

  task automatic test_single();
    int t = -1;
    logic [WIDTH-1:0] bits = '0;
    logic [VW-1:0] got, exp;
    do_reset();
    for (int c = 0; c < int'(PERIOD) + 3; c++) begin
      @(negedge clk);
      resetn = 1'b1;
      if (c == 0) begin rv[0] = 1'b1; rd[0] = 8'hA5; end
      apply(); #1;
      got = dut_vec(); exp = model_expect(); checks++;
      if (got !== exp) begin
        errors++; $display("FAIL single cyc%0d got %b exp %b", c, got, exp);
      end
      if (t < 0 && bus.req_ready[0] === 1'b1) t = c;
      if (t >= 0 && c > t && c <= t + int'(WIDTH)) bits = {bits[WIDTH-2:0], bus.ser_out};
      if (t >= 0 && c == t + int'(PERIOD)) begin
        checks++;
        if (bus.done_pulse !== 1'b1 || bus.done_owner !== OWN_W'(0)) begin
          errors++;
          $display("FAIL single_done got done=%b own=%0d exp done=1 own=0",
                   bus.done_pulse, bus.done_owner);
        end
      end
      model_advance();
    end
    checks++;
    if (t != 0) begin errors++; $display("FAIL single_grant got cyc %0d exp 0", t); end
    checks++;
    if (bits !== 8'hA5) begin errors++; $display("FAIL single_bits got %h exp a5", bits); end
  endtask

`ifdef SHIFT_PARITY_EN
  task automatic test_parity();
    int t = -1;
    logic [VW-1:0] got, exp;
    do_reset();
    for (int c = 0; c < int'(PERIOD) + 2; c++) begin
      @(negedge clk);
      resetn = 1'b1;
      if (c == 0) begin rv[0] = 1'b1; rd[0] = 8'h07; end
      apply(); #1;
      got = dut_vec(); exp = model_expect(); checks++;
      if (got !== exp) begin
        errors++; $display("FAIL parity cyc%0d got %b exp %b", c, got, exp);
      end
      if (t < 0 && bus.req_ready[0] === 1'b1) t = c;
      if (t >= 0 && c == t + int'(WIDTH) + 1) begin
        checks++;
        if (bus.ser_out !== 1'b1 || bus.ser_en !== 1'b1) begin
          errors++; $display("FAIL parity_bit got %b en %b exp 1", bus.ser_out, bus.ser_en);
        end
      end
      if (t >= 0 && c == t + int'(WIDTH + DEPTH) + 2) begin
        checks++;
        if (bus.done_pulse !== 1'b1) begin
          errors++; $display("FAIL parity_done got %b exp 1", bus.done_pulse);
        end
      end
      model_advance();
    end
  endtask
`endif

  task automatic test_two_req();
    int hs_idx[$];
    int hs_cyc[$];
    int code = 0;
    int gap = -1;
    logic [VW-1:0] got, exp;
    do_reset();
    for (int c = 0; c < 2 * int'(PERIOD) + 3; c++) begin
      @(negedge clk);
      resetn = 1'b1;
      for (int i = 0; i < NUM_REQ; i++)
        if (!rv[i]) begin rv[i] = 1'b1; rd[i] = WIDTH'($urandom); end
      apply(); #1;
      got = dut_vec(); exp = model_expect(); checks++;
      if (got !== exp) begin
        errors++; $display("FAIL two_req cyc%0d got %b exp %b", c, got, exp);
      end
      for (int i = 0; i < NUM_REQ; i++)
        if (bus.req_ready[i] === 1'b1) begin hs_idx.push_back(i); hs_cyc.push_back(c); end
      model_advance();
    end
    for (int k = 0; k < 3; k++) code = code * 10 + ((k < hs_idx.size()) ? hs_idx[k] : 9);
    if (hs_cyc.size() >= 2) gap = hs_cyc[1] - hs_cyc[0];
    checks++;
    if (code != 10) begin errors++; $display("FAIL two_req_order got %03d exp 010", code); end
    checks++;
    if (gap != int'(PERIOD)) begin
      errors++; $display("FAIL two_req_gap got %0d exp %0d", gap, PERIOD);
    end
    rv = '0;
  endtask

  task automatic test_wrap();
    int first = -1;
    int second = -1;
    logic [VW-1:0] got, exp;
    do_reset();
    for (int c = 0; c < 2 * int'(PERIOD); c++) begin
      @(negedge clk);
      resetn = 1'b1;
      if (first < 0) begin
        rv[0] = 1'b0;
        if (!rv[1]) begin rv[1] = 1'b1; rd[1] = WIDTH'($urandom); end
      end else begin
        for (int i = 0; i < NUM_REQ; i++)
          if (!rv[i]) begin rv[i] = 1'b1; rd[i] = WIDTH'($urandom); end
      end
      apply(); #1;
      got = dut_vec(); exp = model_expect(); checks++;
      if (got !== exp) begin
        errors++; $display("FAIL wrap cyc%0d got %b exp %b", c, got, exp);
      end
      for (int i = 0; i < NUM_REQ; i++)
        if (bus.req_ready[i] === 1'b1) begin
          if (first < 0) first = i;
          else if (second < 0) second = i;
        end
      model_advance();
    end
    checks++;
    if (first != 1 || second != 0) begin
      errors++; $display("FAIL wrap_order got %0d,%0d exp 1,0", first, second);
    end
    rv = '0;
  endtask

  task automatic test_reset_mid();
    logic [VW-1:0] got, exp;
    do_reset();
    for (int c = 0; c < int'(PERIOD) + 10; c++) begin
      @(negedge clk);
      resetn = (c != 5);
      if (c == 0) begin rv[0] = 1'b1; rd[0] = 8'hA5; end
      if (c == 6) begin rv = '1; rd[0] = WIDTH'($urandom); rd[1] = WIDTH'($urandom); end
      apply(); #1;
      got = dut_vec(); exp = model_expect(); checks++;
      if (got !== exp) begin
        errors++; $display("FAIL reset_mid cyc%0d got %b exp %b", c, got, exp);
      end
      if (c == 6) begin
        checks++;
        if ({bus.ser_en, bus.busy, bus.done_pulse} !== 3'b000 || bus.req_ready !== 2'b01) begin
          errors++;
          $display("FAIL reset_mid_abort got en/busy/done %b%b%b rdy %b exp 000 rdy 01",
                   bus.ser_en, bus.busy, bus.done_pulse, bus.req_ready);
        end
      end
      model_advance();
    end
    rv = '0;
  endtask

  task automatic test_drop();
    int extra_hs = 0;
    int en_cnt = 0;
    logic [VW-1:0] got, exp;
    do_reset();
    for (int c = 0; c < int'(PERIOD) + 8; c++) begin
      @(negedge clk);
      resetn = 1'b1;
      if (c == 0) begin rv[1] = 1'b1; rd[1] = WIDTH'($urandom); end
      if (c == 2) begin rv[0] = 1'b1; rd[0] = WIDTH'($urandom); end
      if (c == 6) rv[0] = 1'b0;
      apply(); #1;
      got = dut_vec(); exp = model_expect(); checks++;
      if (got !== exp) begin
        errors++; $display("FAIL drop cyc%0d got %b exp %b", c, got, exp);
      end
      if (c > 0 && bus.req_ready !== '0) extra_hs++;
      if (bus.ser_en === 1'b1) en_cnt++;
      model_advance();
    end
    checks++;
    if (extra_hs != 0 || en_cnt != int'(SL + DEPTH)) begin
      errors++;
      $display("FAIL drop_spurious got hs=%0d en=%0d exp hs=0 en=%0d", extra_hs, en_cnt,
               SL + DEPTH);
    end
  endtask

  task automatic test_random();
    logic [VW-1:0] got, exp;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      resetn = ($urandom_range(99) != 0);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!rv[i]) begin
          if ($urandom_range(3) == 0) begin rv[i] = 1'b1; rd[i] = WIDTH'($urandom); end
        end else if ($urandom_range(19) == 0) begin
          rv[i] = 1'b0;
        end
      end
      apply(); #1;
      got = dut_vec(); exp = model_expect(); checks++;
      if (got !== exp) begin
        errors++; $display("FAIL random cyc%0d got %b exp %b", c, got, exp);
      end
      model_advance();
    end
    resetn = 1'b1;
  endtask

  initial begin
    rv = '0;
    for (int i = 0; i < NUM_REQ; i++) rd[i] = '0;
    apply();
    test_reset();
    test_single();
`ifdef SHIFT_PARITY_EN
    test_parity();
`endif
    test_two_req();
    test_wrap();
    test_reset_mid();
    test_drop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
